// File: rtl/led_spread_if.sv
// Handshake/control bundle for the LED spread generator.
// The master drives requests; the slave returns the LED frame and status.
interface led_spread_if #(
  parameter int HALF  = 9,
  parameter int RPT_W = 4
);
  logic              start;
  logic              enable;
  logic              abort;
  logic              tick;
  logic [1:0]        mode;
  logic [RPT_W-1:0]  repeats;
  logic [2*HALF-1:0] out;
  logic              busy;
  logic              done;

  modport master (
    output start, enable, abort, tick, mode, repeats,
    input  out, busy, done
  );

  modport slave (
    input  start, enable, abort, tick, mode, repeats,
    output out, busy, done
  );
endinterface

// File: rtl/led_spread_gen.sv
// LED spread pattern generator: fills or sweeps LEDs across a two-half strip one frame per tick.
// Optional macro LED_SPREAD_BLINK_EN inserts a dark frame after every lit frame.
module led_spread_gen #(
  parameter int HALF  = 9,
  parameter int RPT_W = 4
) (
  input  logic        clk,
  input  logic        localReset,
  led_spread_if.slave bus
);
  localparam int            SW        = $clog2(HALF + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(HALF);
  localparam logic [SW-1:0] STEP_ONE  = SW'(1);

`ifdef LED_SPREAD_BLINK_EN
  typedef enum logic [1:0] {IDLE, RUN, BLANK, DONE} state_t;
  localparam state_t LIT_NEXT = BLANK;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam state_t LIT_NEXT = RUN;
`endif

  state_t            state;
  logic [SW-1:0]     step;
  logic [RPT_W-1:0]  pass;
  logic [RPT_W-1:0]  rpt_q;
  logic [1:0]        mode_q;
  logic [2*HALF-1:0] frame_q;
  logic              busy_q;
  logic              done_q;

  logic              accept;
  logic              in_blank;
  logic              last_pass;
  logic [RPT_W-1:0]  rpt_eff;
  logic [SW-1:0]     step_inc;

  assign accept    = bus.tick & bus.enable;
  assign rpt_eff   = (rpt_q == '0) ? RPT_W'(1) : rpt_q;
  assign last_pass = (pass >= rpt_eff);
  assign step_inc  = step + STEP_ONE;

`ifdef LED_SPREAD_BLINK_EN
  assign in_blank = (state == BLANK);
`else
  assign in_blank = 1'b0;
`endif

  // Frame k of a pattern; left half occupies the upper HALF bits.
  function automatic logic [2*HALF-1:0] frame_of(input logic [1:0] m, input logic [SW-1:0] k);
    logic [HALF-1:0] fill;
    logic [HALF-1:0] fill_rev;
    logic [HALF-1:0] dot_l;
    logic [HALF-1:0] dot_r;
    int              kk;
    kk = int'(k);
    for (int i = 0; i < HALF; i++) begin
      fill[i]     = (i < kk);
      fill_rev[i] = (i >= HALF - kk);
      dot_l[i]    = (i == kk - 1);
      dot_r[i]    = (i == HALF - kk);
    end
    case (m)
      2'b01:   frame_of = {fill_rev, fill};
      2'b10:   frame_of = {dot_l, dot_r};
      default: frame_of = {fill, fill_rev};
    endcase
  endfunction

  always_ff @(posedge clk or posedge localReset) begin
    if (localReset) begin
      state   <= IDLE;
      step    <= '0;
      pass    <= '0;
      rpt_q   <= '0;
      mode_q  <= '0;
      frame_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && bus.enable) begin
            state   <= RUN;
            busy_q  <= 1'b1;
            mode_q  <= (bus.mode == 2'b11) ? 2'b00 : bus.mode;
            rpt_q   <= bus.repeats;
            step    <= '0;
            pass    <= RPT_W'(1);
            frame_q <= '0;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          // Abort wins over a simultaneous tick and never produces done.
          if (bus.abort) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            step    <= '0;
            pass    <= '0;
            frame_q <= '0;
          end else if (accept) begin
            if (in_blank) begin
              state   <= RUN;
              frame_q <= '0;
            end else if (step != STEP_LAST) begin
              step    <= step_inc;
              frame_q <= frame_of(mode_q, step_inc);
              state   <= LIT_NEXT;
            end else if (!last_pass) begin
              pass    <= pass + RPT_W'(1);
              step    <= STEP_ONE;
              frame_q <= frame_of(mode_q, STEP_ONE);
              state   <= LIT_NEXT;
            end else begin
              frame_q <= '0;
              state   <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.out  = frame_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
